// File: rtl/mem_resp_pkg.sv
// Shared types for the memory line responder: FSM states, transaction kind,
// and a width helper for index counters.
package mem_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_READ_BEAT  = 3'd1,
    ST_WRITE_WAIT = 3'd2,
    ST_RESPOND    = 3'd3,
    ST_RELEASE    = 3'd4
  } mem_resp_state_t;

  typedef enum logic {
    KIND_READ  = 1'b0,
    KIND_WRITE = 1'b1
  } mem_resp_kind_t;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after the
// pointer (wrapping) wins; grant is returned one-hot and as an index.
module rr_arbiter
  import mem_resp_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_bits(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < N; i++) begin
      w_cand = IDX_W'((int'(i_ptr) + i) % N);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/mem_line_responder.sv
// Serves line reads and single-word writes from several core channels, one
// at a time, against a single-word external memory port.
module mem_line_responder
  import mem_resp_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int READ_NUM     = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_CHANNELS-1:0]                   consumer_read_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0]         consumer_read_address,
  output logic [NUM_CHANNELS-1:0]                   consumer_read_ready,
  output logic [NUM_CHANNELS*READ_NUM*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CHANNELS-1:0]                   consumer_write_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0]         consumer_write_address,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]         consumer_write_data,
  output logic [NUM_CHANNELS-1:0]                   consumer_write_ready,
  output logic                                      mem_read_valid,
  output logic [ADDR_BITS-1:0]                      mem_read_address,
  input  logic                                      mem_read_ready,
  input  logic [DATA_BITS-1:0]                      mem_read_data,
  output logic                                      mem_write_valid,
  output logic [ADDR_BITS-1:0]                      mem_write_address,
  output logic [DATA_BITS-1:0]                      mem_write_data,
  input  logic                                      mem_write_ready
);

  localparam int CH_W   = idx_bits(NUM_CHANNELS);
  localparam int BEAT_W = idx_bits(READ_NUM);
  localparam int LINE_W = READ_NUM * DATA_BITS;

  mem_resp_state_t                  r_state;
  mem_resp_kind_t                   r_kind;
  logic [CH_W-1:0]                  r_ch;
  logic [CH_W-1:0]                  r_rr;
  logic [BEAT_W-1:0]                r_beat;
  logic [ADDR_BITS-1:0]             r_addr;
  logic [DATA_BITS-1:0]             r_wdata;
  logic [LINE_W-1:0]                r_buf;
  logic [NUM_CHANNELS*LINE_W-1:0]   r_lines;

  logic [NUM_CHANNELS-1:0] w_req;
  logic [NUM_CHANNELS-1:0] w_grant;
  logic [CH_W-1:0]         w_idx;
  logic                    w_any;
  logic                    w_grant_rd;
  logic [ADDR_BITS-1:0]    w_rd_base;
  logic [ADDR_BITS-1:0]    w_wr_addr;
  logic [DATA_BITS-1:0]    w_wr_data;
  logic                    w_served_valid;
  logic                    w_last;
  logic [LINE_W-1:0]       w_line_next;

  assign w_req = consumer_read_valid | consumer_write_valid;

  rr_arbiter #(
    .N     (NUM_CHANNELS),
    .IDX_W (CH_W)
  ) u_arb (
    .i_req   (w_req),
    .i_ptr   (r_rr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Request fields of the channel being granted, and the held valid of the
  // channel currently being served (watched in RELEASE).
  always_comb begin
    w_grant_rd     = |(w_grant & consumer_read_valid);
    w_rd_base      = '0;
    w_wr_addr      = '0;
    w_wr_data      = '0;
    w_served_valid = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (w_idx == CH_W'(c)) begin
        w_rd_base = consumer_read_address[c*ADDR_BITS +: ADDR_BITS];
        w_wr_addr = consumer_write_address[c*ADDR_BITS +: ADDR_BITS];
        w_wr_data = consumer_write_data[c*DATA_BITS +: DATA_BITS];
      end
      if (r_ch == CH_W'(c)) begin
        w_served_valid = (r_kind == KIND_READ) ? consumer_read_valid[c]
                                               : consumer_write_valid[c];
      end
    end
  end

  assign w_last = (r_beat == BEAT_W'(READ_NUM - 1));

  always_comb begin
    w_line_next = r_buf;
    for (int k = 0; k < READ_NUM; k++) begin
      if (r_beat == BEAT_W'(k)) begin
        w_line_next[k*DATA_BITS +: DATA_BITS] = mem_read_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_kind  <= KIND_READ;
      r_ch    <= '0;
      r_rr    <= '0;
      r_beat  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_buf   <= '0;
      r_lines <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_ch   <= w_idx;
            r_rr   <= (w_idx == CH_W'(NUM_CHANNELS - 1)) ? '0 : w_idx + CH_W'(1);
            r_beat <= '0;
            r_buf  <= '0;
            if (w_grant_rd) begin
              r_kind  <= KIND_READ;
              r_addr  <= w_rd_base;
              r_state <= ST_READ_BEAT;
            end else begin
              r_kind  <= KIND_WRITE;
              r_addr  <= w_wr_addr;
              r_wdata <= w_wr_data;
              r_state <= ST_WRITE_WAIT;
            end
          end
        end
        ST_READ_BEAT: begin
          if (mem_read_ready) begin
            r_buf <= w_line_next;
            if (w_last) begin
              // The line becomes visible to the channel in the RESPOND cycle.
              for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (r_ch == CH_W'(c)) r_lines[c*LINE_W +: LINE_W] <= w_line_next;
              end
              r_state <= ST_RESPOND;
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end
        ST_WRITE_WAIT: begin
          if (mem_write_ready) r_state <= ST_RESPOND;
        end
        ST_RESPOND: begin
          r_state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!w_served_valid) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    consumer_read_ready  = '0;
    consumer_write_ready = '0;
    if (r_state == ST_RESPOND) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (r_ch == CH_W'(c)) begin
          if (r_kind == KIND_READ) consumer_read_ready[c]  = 1'b1;
          else                     consumer_write_ready[c] = 1'b1;
        end
      end
    end
  end

  assign consumer_read_data = r_lines;

  // Beat address wraps modulo the address space; no line alignment.
  assign mem_read_valid    = (r_state == ST_READ_BEAT);
  assign mem_read_address  = r_addr + ADDR_BITS'(r_beat);
  assign mem_write_valid   = (r_state == ST_WRITE_WAIT);
  assign mem_write_address = r_addr;
  assign mem_write_data    = r_wdata;

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder with a behavioural memory whose
// per-request wait cycles are set by the stimulus.
module tb_mem_line_responder;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int RN = 4;
  localparam int LW = RN * DW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    rd_valid, rd_ready, wr_valid, wr_ready;
  logic [N*AW-1:0] rd_addr, wr_addr;
  logic [N*DW-1:0] wr_data;
  logic [N*LW-1:0] rd_data;
  logic            m_rv, m_rr, m_wv, m_wr;
  logic [AW-1:0]   m_ra, m_wa;
  logic [DW-1:0]   m_rd, m_wd;

  mem_line_responder dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (rd_valid),
    .consumer_read_address  (rd_addr),
    .consumer_read_ready    (rd_ready),
    .consumer_read_data     (rd_data),
    .consumer_write_valid   (wr_valid),
    .consumer_write_address (wr_addr),
    .consumer_write_data    (wr_data),
    .consumer_write_ready   (wr_ready),
    .mem_read_valid         (m_rv),
    .mem_read_address       (m_ra),
    .mem_read_ready         (m_rr),
    .mem_read_data          (m_rd),
    .mem_write_valid        (m_wv),
    .mem_write_address      (m_wa),
    .mem_write_data         (m_wd),
    .mem_write_ready        (m_wr)
  );

  // Behavioural memory: mem[i] = i after init, ready after wait cycles.
  logic [7:0]    mem [256];
  int            rd_wait = 0, wr_wait = 0, r_cnt = 0, w_cnt = 0, n_writes = 0;
  logic          init_mem = 1'b1;
  logic [AW-1:0] beat_log [$];

  assign m_rr = m_rv && (r_cnt == rd_wait);
  assign m_wr = m_wv && (w_cnt == wr_wait);
  assign m_rd = mem[m_ra];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      n_writes <= 0;
    end else if (m_wv && m_wr) begin
      mem[m_wa] <= m_wd;
      n_writes  <= n_writes + 1;
    end
    r_cnt <= (m_rv && !m_rr) ? r_cnt + 1 : 0;
    w_cnt <= (m_wv && !m_wr) ? w_cnt + 1 : 0;
    if (m_rv && m_rr) beat_log.push_back(m_ra);
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  ch;
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    int          wait_c;
    int          exp_lat;
    logic [31:0] exp_line;
  } vec_t;

  // Issue one request from an idle responder and check its completion.
  task automatic run_one(input string tag, input vec_t v);
    int          lat;
    int          nw0;
    logic [31:0] exp_b, got_b;
    lat = 0;
    nw0 = n_writes;
    beat_log.delete();
    rd_wait = v.wait_c;
    wr_wait = v.wait_c;
    if (v.wr) begin
      wr_addr[v.ch*AW +: AW] = v.addr;
      wr_data[v.ch*DW +: DW] = v.wdata;
      wr_valid[v.ch] = 1'b1;
    end else begin
      rd_addr[v.ch*AW +: AW] = v.addr;
      rd_valid[v.ch] = 1'b1;
    end
    for (int k = 1; k <= 60; k++) begin
      tick();
      if ((v.wr ? wr_ready[v.ch] : rd_ready[v.ch]) === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_ready_vec"}, {rd_ready, wr_ready},
          v.wr ? {4'b0000, 4'b0001 << v.ch} : {4'b0001 << v.ch, 4'b0000});
    if (v.wr) begin
      check({tag, "_mem_word"}, mem[v.addr], v.wdata);
      check({tag, "_n_writes"}, n_writes - nw0, 1);
    end else begin
      check({tag, "_line"}, rd_data[v.ch*LW +: LW], v.exp_line);
      exp_b = '0;
      got_b = '0;
      for (int k = 0; k < RN; k++) exp_b[k*8 +: 8] = v.addr + 8'(k);
      check({tag, "_n_beats"}, beat_log.size(), RN);
      if (beat_log.size() == RN)
        for (int k = 0; k < RN; k++) got_b[k*8 +: 8] = beat_log[k];
      check({tag, "_beat_addrs"}, got_b, exp_b);
    end
    rd_valid[v.ch] = 1'b0;
    wr_valid[v.ch] = 1'b0;
    tick();
    check({tag, "_pulse_1cyc"}, {rd_ready, wr_ready}, 0);
    tick();
    tick();
  endtask

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          cnt [N];
    logic [31:0] line_at [N];
    int          order [$];
    logic [7:0]  ord_pk;
    logic        bad;
    int          nw0;
    vec_t        fresh;

    rd_valid = '0; wr_valid = '0;
    rd_addr  = '0; wr_addr  = '0; wr_data = '0;
    reset    = 1'b1;
    init_mem = 1'b1;
    tick(); tick(); tick();
    check("rst_ctrl", {rd_ready, wr_ready, m_rv, m_wv}, 0);
    check("rst_addr_data", {m_ra, m_wa, m_wd}, 0);
    check("rst_lines_zero", (rd_data == '0), 1);
    init_mem = 1'b0;
    reset    = 1'b0;
    tick();

    vecs[0] = '{ch: 2'd0, wr: 1'b0, addr: 8'h10, wdata: 8'h00, wait_c: 0, exp_lat: 5, exp_line: 32'h13121110};
    vecs[1] = '{ch: 2'd1, wr: 1'b0, addr: 8'hFE, wdata: 8'h00, wait_c: 0, exp_lat: 5, exp_line: 32'h0100FFFE};
    vecs[2] = '{ch: 2'd2, wr: 1'b1, addr: 8'h20, wdata: 8'hAB, wait_c: 3, exp_lat: 5, exp_line: 32'h0};
    vecs[3] = '{ch: 2'd3, wr: 1'b0, addr: 8'h1E, wdata: 8'h00, wait_c: 1, exp_lat: 9, exp_line: 32'h21AB1F1E};
    vecs[4] = '{ch: 2'd0, wr: 1'b1, addr: 8'h05, wdata: 8'h5A, wait_c: 0, exp_lat: 2, exp_line: 32'h0};
    vecs[5] = '{ch: 2'd0, wr: 1'b0, addr: 8'h04, wdata: 8'h00, wait_c: 0, exp_lat: 5, exp_line: 32'h07065A04};
    for (int v = 0; v < 6; v++) run_one($sformatf("vec%0d", v), vecs[v]);
    check("ch3_line_held", rd_data[3*LW +: LW], 32'h21AB1F1E);

    // Reset during beat 2 of a line read: no pulse, everything cleared.
    rd_wait = 0;
    rd_addr[0*AW +: AW] = 8'h10;
    rd_valid[0] = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rd_ready != '0) bad = 1'b1;
      if (m_rv && m_ra == 8'h12) break;
    end
    check("mid_rst_at_beat2", {m_rv, m_ra}, {1'b1, 8'h12});
    reset = 1'b1;
    tick();
    check("mid_rst_outputs", {rd_ready, wr_ready, m_rv, m_wv, m_ra, m_wa, m_wd}, 0);
    check("mid_rst_lines_zero", (rd_data == '0), 1);
    rd_valid[0] = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (rd_ready != '0) bad = 1'b1;
    end
    check("mid_rst_no_pulse", bad, 1'b0);
    fresh = '{ch: 2'd2, wr: 1'b0, addr: 8'h30, wdata: 8'h00, wait_c: 0, exp_lat: 5, exp_line: 32'h33323130};
    run_one("post_rst", fresh);

    // All four channels request together and hold until served.
    do_reset();
    rd_wait = 0;
    for (int c = 0; c < N; c++) begin
      cnt[c] = 0;
      line_at[c] = '0;
      rd_addr[c*AW +: AW] = 8'h40 + 8'(4 * c);
    end
    rd_valid = 4'hF;
    for (int k = 0; k < 60; k++) begin
      tick();
      for (int c = 0; c < N; c++) begin
        if (rd_ready[c]) begin
          order.push_back(c);
          cnt[c]++;
          line_at[c] = rd_data[c*LW +: LW];
          rd_valid[c] = 1'b0;
        end
      end
    end
    check("rr_n_served", order.size(), 4);
    ord_pk = 8'hFF;
    if (order.size() == 4)
      ord_pk = {order[3][1:0], order[2][1:0], order[1][1:0], order[0][1:0]};
    check("rr_order", ord_pk, {2'd3, 2'd2, 2'd1, 2'd0});
    check("rr_once_each", {cnt[3][7:0], cnt[2][7:0], cnt[1][7:0], cnt[0][7:0]}, 32'h01010101);
    check("rr_line_ch0", line_at[0], 32'h43424140);
    check("rr_line_ch3", line_at[3], 32'h4F4E4D4C);

    // Pointer has wrapped to channel 0, so ch0 beats ch3.
    rd_addr[0*AW +: AW] = 8'h50;
    rd_addr[3*AW +: AW] = 8'h60;
    rd_valid = 4'b1001;
    ord_pk = 8'h00;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (rd_ready != '0) begin
        ord_pk = {4'h0, rd_ready};
        break;
      end
    end
    check("rr_wrap_first", ord_pk, 8'h01);
    rd_valid[0] = 1'b0;
    ord_pk = 8'h00;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (rd_ready != '0) begin
        ord_pk = {4'h0, rd_ready};
        break;
      end
    end
    check("rr_wrap_second", ord_pk, 8'h08);
    rd_valid = '0;
    tick(); tick(); tick();

    // Held write valid must not be served twice.
    nw0 = n_writes;
    wr_wait = 0;
    wr_addr[1*AW +: AW] = 8'h70;
    wr_data[1*DW +: DW] = 8'h3C;
    wr_valid[1] = 1'b1;
    ord_pk = 8'h00;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (wr_ready[1]) begin
        ord_pk = 8'h01;
        break;
      end
    end
    check("hold_first_ready", ord_pk, 8'h01);
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (wr_ready != '0 || m_wv) bad = 1'b1;
    end
    check("hold_no_reservice", bad, 1'b0);
    wr_valid[1] = 1'b0;
    tick(); tick(); tick();
    check("hold_one_write", n_writes - nw0, 1);
    check("hold_mem_word", mem[8'h70], 8'h3C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
